dual_edge_pipe: RTL and testbench
=================================

# dual_edge_pipe

Parametrised two-edge arithmetic pipeline, successor to the fixed-width multiple-edge capture block. Two operands are combined on the rising edge through a configurable-depth pipeline (output `f`), and the result is re-registered on the falling edge of the same clock (output `t`). Adds valid tagging, add/subtract mode and an accepted-sample counter. Used as a datapath building block and as a reference for edge-ordering and nonblocking-update checks.

## Interface
Parameters:
- `AW`, 2: width of operand `a`
- `DW`, 3: width of operand `d`
- `DEPTH`, 2: number of rising-edge pipeline stages, ≥1
- `CNTW`, 4: width of the sample counter
- derived `OW` = max(AW,DW)+1: result width (4 at defaults)

Ports:
- `clk`  in  1  single clock; rising and falling edges both used
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands valid this rising edge
- `op`  in  1  0 = add, 1 = subtract (a − d)
- `a`  in  AW  operand A, unsigned
- `d`  in  DW  operand D, unsigned
- `f`  out  OW  rising-edge pipeline result
- `f_valid`  out  1  `f` holds a valid result
- `t`  out  OW  falling-edge copy of `f`
- `t_valid`  out  1  `t` holds a valid result
- `sample_cnt`  out  CNTW  count of accepted samples

## Operation
- Stage 0 (rising edge):
  - if `in_valid`: data = zero-extended a op zero-extended d, computed modulo 2^OW; valid = 1.
  - else: valid = 0; data holds its previous value.
- Stages 1..DEPTH-1 (rising edge): each stage copies data and valid from the previous stage unconditionally. No stall and no backpressure.
- `f` and `f_valid` are the last stage.
- Falling edge: `t` <= `f`, `t_valid` <= `f_valid`, sampled at that falling edge.
- `sample_cnt` increments on each rising edge with `in_valid`=1. It wraps from 2^CNTW−1 to 0 with no saturation or flag.
- Subtract underflow wraps: 2 − 5 = 13 at OW=4.
- `op` is sampled with the operands. Each sample carries its own mode, so mixing add and subtract across back-to-back samples is legal.
- Reset:
  - rising edge with `rst`=1: all stage data/valid, `f`, `f_valid` and `sample_cnt` become 0. `in_valid` on that edge is ignored.
  - falling edge with `rst`=1: `t` and `t_valid` become 0.
- Reset mid-operation discards all in-flight samples. No stale valid emerges after `rst` deasserts.
- Reset value of every output is 0.

## Timing
- Sample accepted at rising edge N appears on `f`/`f_valid` after rising edge N+DEPTH−1. With DEPTH=1, it updates at edge N itself.
- `t`/`t_valid` follow `f` by half a cycle: updated at the falling edge between rising edges N+DEPTH−1 and N+DEPTH.
- Throughput: one sample per cycle. Bubbles (`in_valid`=0) propagate as `f_valid`=0 with `f` holding its last data.
- All registers use nonblocking updates. A rising-edge stage never sees a same-edge update of its predecessor, so there is exactly one stage of delay per stage.
- `rst` asserted for one full cycle clears both edge domains. Asserting it for only a half-cycle window is illegal.

## Structure
- Shared package `dual_edge_pkg`:
  - `OP_ADD`=1'b0, `OP_SUB`=1'b1
  - function computing OW from AW/DW
- Sub-module `pipe_stage` (parameter W): one rising-edge data+valid register with synchronous reset. Instantiated DEPTH−1 times via generate. Stage 0 and the falling-edge register stay in the top level.

## Test plan
- Defaults, `rst` high for 2 cycles, then released:
  - all outputs are 0 during reset.
  - a=3, d=4, add, valid at edge N → `f`=7, `f_valid`=1 after edge N+1; `t`=7 at the next falling edge.
- Back-to-back samples a=3,d=4 add, then a=2,d=5 sub → `f` shows 7 then 13 on consecutive cycles; `t` trails each by half a cycle; `sample_cnt`=2.
- Bubble: valid, invalid, valid with a=1,d=1 then a=3,d=2 (add) → `f_valid` pattern 1,0,1; `f` holds 2 during the bubble, then shows 5.
- Counter wrap, CNTW=4: 16 accepted samples → `sample_cnt` returns to 0. A 17th sample gives 1.
- Reset mid-flight, DEPTH=3: accept a=3,d=4, assert `rst` one cycle later → no `f_valid` or `t_valid` pulse for that sample; all outputs 0 after reset.
- Parameter sweep AW=8, DW=8, DEPTH=1: a=255,d=255 add → `f`=510 at the same edge; sub a=0,d=1 → `f`=511.

Source files
------------

// File: rtl/dual_edge_pkg.sv
// Shared definitions for the two-edge arithmetic pipeline: operation encoding
// and the result-width rule derived from the operand widths.
package dual_edge_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // One extra bit over the wider operand so an add never overflows.
    function automatic int unsigned calc_ow(input int unsigned aw, input int unsigned dw);
        return ((aw > dw) ? aw : dw) + 1;
    endfunction

endpackage

// File: rtl/dual_edge_pipe_stage.sv
// One rising-edge data+valid register of the pipeline. Copies its
// predecessor every cycle; synchronous active-high reset clears both.
module pipe_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    input  logic         v_i,
    output logic [W-1:0] d_o,
    output logic         v_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= d_i;
            valid_q <= v_i;
        end
    end

    assign d_o = data_q;
    assign v_o = valid_q;

endmodule

// File: rtl/dual_edge_pipe.sv
// Two-edge arithmetic pipeline: operands combined at stage 0 on the rising
// edge, DEPTH rising-edge stages in total, result re-registered on the falling edge.
module dual_edge_pipe
    import dual_edge_pkg::*;
#(
    parameter  int unsigned AW    = 2,
    parameter  int unsigned DW    = 3,
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned CNTW  = 4,
    localparam int unsigned OW    = calc_ow(AW, DW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            op,
    input  logic [AW-1:0]   a,
    input  logic [DW-1:0]   d,
    output logic [OW-1:0]   f,
    output logic            f_valid,
    output logic [OW-1:0]   t,
    output logic            t_valid,
    output logic [CNTW-1:0] sample_cnt
);

    logic [OW-1:0]   s0_data_q, s0_data_d;
    logic            s0_valid_q, s0_valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [OW-1:0]   t_q;
    logic            t_valid_q;

    logic [OW-1:0]   stage_data  [DEPTH];
    logic            stage_valid [DEPTH];

    // Data holds across bubbles so f keeps its last result while f_valid drops.
    always_comb begin
        s0_data_d  = s0_data_q;
        s0_valid_d = 1'b0;
        cnt_d      = cnt_q;
        if (in_valid) begin
            s0_valid_d = 1'b1;
            cnt_d      = cnt_q + CNTW'(1);
            if (op_e'(op) == OP_SUB)
                s0_data_d = OW'(a) - OW'(d);
            else
                s0_data_d = OW'(a) + OW'(d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_data_q  <= '0;
            s0_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s0_data_q  <= s0_data_d;
            s0_valid_q <= s0_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stage_data[0]  = s0_data_q;
    assign stage_valid[0] = s0_valid_q;

    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
        pipe_stage #(.W(OW)) u_stage (
            .clk (clk),
            .rst (rst),
            .d_i (stage_data[i-1]),
            .v_i (stage_valid[i-1]),
            .d_o (stage_data[i]),
            .v_o (stage_valid[i])
        );
    end

    assign f       = stage_data[DEPTH-1];
    assign f_valid = stage_valid[DEPTH-1];

    always_ff @(negedge clk) begin
        if (rst) begin
            t_q       <= '0;
            t_valid_q <= 1'b0;
        end else begin
            t_q       <= f;
            t_valid_q <= f_valid;
        end
    end

    assign t          = t_q;
    assign t_valid    = t_valid_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_dual_edge_pipe.sv
// Directed bench for dual_edge_pipe: default, DEPTH=3 and 8-bit/DEPTH=1 instances
// share clock and control inputs; each scenario checks the instance it targets.
module tb_dual_edge_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] d8 = '0;

    logic [3:0] f0, t0, f1, t1, cnt0, cnt1, cnt2;
    logic       fv0, tv0, fv1, tv1, fv2, tv2;
    logic [8:0] f2, t2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dual_edge_pipe #(.AW(2), .DW(3), .DEPTH(2), .CNTW(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a8[1:0]), .d(d8[2:0]),
        .f(f0), .f_valid(fv0), .t(t0), .t_valid(tv0), .sample_cnt(cnt0));

    dual_edge_pipe #(.AW(2), .DW(3), .DEPTH(3), .CNTW(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a8[1:0]), .d(d8[2:0]),
        .f(f1), .f_valid(fv1), .t(t1), .t_valid(tv1), .sample_cnt(cnt1));

    dual_edge_pipe #(.AW(8), .DW(8), .DEPTH(1), .CNTW(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .a(a8), .d(d8),
        .f(f2), .f_valid(fv2), .t(t2), .t_valid(tv2), .sample_cnt(cnt2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a8 = 8'd3; d8 = 8'd4; op = 1'b0;
        step();
        checks++; if (f0 !== 4'd0)   begin errors++; $display("FAIL reset_f got %0d exp 0", f0); end
        checks++; if (fv0 !== 1'b0)  begin errors++; $display("FAIL reset_fv got %0b exp 0", fv0); end
        checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
        step();
        checks++; if (t0 !== 4'd0)   begin errors++; $display("FAIL reset_t got %0d exp 0", t0); end
        checks++; if (tv0 !== 1'b0)  begin errors++; $display("FAIL reset_tv got %0b exp 0", tv0); end
        checks++; if (f2 !== 9'd0)   begin errors++; $display("FAIL reset_f2 got %0d exp 0", f2); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_basic();
        in_valid = 1'b1; a8 = 8'd3; d8 = 8'd4; op = 1'b0;
        step();
        in_valid = 1'b0;
        checks++; if (fv0 !== 1'b0) begin errors++; $display("FAIL basic_early_fv got %0b exp 0", fv0); end
        step();
        checks++; if (f0 !== 4'd7)  begin errors++; $display("FAIL basic_f got %0d exp 7", f0); end
        checks++; if (fv0 !== 1'b1) begin errors++; $display("FAIL basic_fv got %0b exp 1", fv0); end
        checks++; if (tv0 !== 1'b0) begin errors++; $display("FAIL basic_t_lag got %0b exp 0", tv0); end
        half();
        checks++; if (t0 !== 4'd7)  begin errors++; $display("FAIL basic_t got %0d exp 7", t0); end
        checks++; if (tv0 !== 1'b1) begin errors++; $display("FAIL basic_tv got %0b exp 1", tv0); end
        checks++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", cnt0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; a8 = 8'd3; d8 = 8'd4; op = 1'b0;
        step();
        a8 = 8'd2; d8 = 8'd5; op = 1'b1;
        step();
        in_valid = 1'b0; op = 1'b0;
        checks++; if (f0 !== 4'd7)  begin errors++; $display("FAIL b2b_f1 got %0d exp 7", f0); end
        checks++; if (fv0 !== 1'b1) begin errors++; $display("FAIL b2b_fv1 got %0b exp 1", fv0); end
        half();
        checks++; if (t0 !== 4'd7)  begin errors++; $display("FAIL b2b_t1 got %0d exp 7", t0); end
        step();
        checks++; if (f0 !== 4'd13) begin errors++; $display("FAIL b2b_f2 got %0d exp 13", f0); end
        checks++; if (fv0 !== 1'b1) begin errors++; $display("FAIL b2b_fv2 got %0b exp 1", fv0); end
        checks++; if (t0 !== 4'd7)  begin errors++; $display("FAIL b2b_t_hold got %0d exp 7", t0); end
        half();
        checks++; if (t0 !== 4'd13) begin errors++; $display("FAIL b2b_t2 got %0d exp 13", t0); end
        checks++; if (cnt0 !== 4'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", cnt0); end
        step();
        checks++; if (fv0 !== 1'b0) begin errors++; $display("FAIL b2b_drain_fv got %0b exp 0", fv0); end
        checks++; if (f0 !== 4'd13) begin errors++; $display("FAIL b2b_drain_f got %0d exp 13", f0); end
    endtask

    task automatic test_bubble();
        do_reset();
        in_valid = 1'b1; a8 = 8'd1; d8 = 8'd1; op = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (f0 !== 4'd2 || fv0 !== 1'b1) begin errors++; $display("FAIL bubble_s1 got f=%0d v=%0b exp f=2 v=1", f0, fv0); end
        in_valid = 1'b1; a8 = 8'd3; d8 = 8'd2;
        step();
        in_valid = 1'b0;
        checks++; if (f0 !== 4'd2 || fv0 !== 1'b0) begin errors++; $display("FAIL bubble_gap got f=%0d v=%0b exp f=2 v=0", f0, fv0); end
        half();
        checks++; if (t0 !== 4'd2 || tv0 !== 1'b0) begin errors++; $display("FAIL bubble_t_gap got t=%0d v=%0b exp t=2 v=0", t0, tv0); end
        step();
        checks++; if (f0 !== 4'd5 || fv0 !== 1'b1) begin errors++; $display("FAIL bubble_s2 got f=%0d v=%0b exp f=5 v=1", f0, fv0); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        in_valid = 1'b1; a8 = 8'd0; d8 = 8'd0; op = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++; if (cnt0 !== 4'd15) begin errors++; $display("FAIL wrap_15 got %0d exp 15", cnt0); end
        step();
        checks++; if (cnt0 !== 4'd0)  begin errors++; $display("FAIL wrap_16 got %0d exp 0", cnt0); end
        step();
        in_valid = 1'b0;
        checks++; if (cnt0 !== 4'd1)  begin errors++; $display("FAIL wrap_17 got %0d exp 1", cnt0); end
    endtask

    task automatic test_depth3();
        do_reset();
        in_valid = 1'b1; a8 = 8'd3; d8 = 8'd4; op = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (fv1 !== 1'b0) begin errors++; $display("FAIL d3_early_fv got %0b exp 0", fv1); end
        step();
        checks++; if (f1 !== 4'd7 || fv1 !== 1'b1) begin errors++; $display("FAIL d3_latency got f=%0d v=%0b exp f=7 v=1", f1, fv1); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        in_valid = 1'b1; a8 = 8'd3; d8 = 8'd4; op = 1'b0;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        checks++; if (fv1 !== 1'b0 || f1 !== 4'd0) begin errors++; $display("FAIL mid_rst_f got f=%0d v=%0b exp 0", f1, fv1); end
        half();
        rst = 1'b0;
        checks++; if (tv1 !== 1'b0 || t1 !== 4'd0) begin errors++; $display("FAIL mid_rst_t got t=%0d v=%0b exp 0", t1, tv1); end
        step();
        checks++; if (fv1 !== 1'b0) begin errors++; $display("FAIL mid_stale1 got %0b exp 0", fv1); end
        step();
        checks++; if (fv1 !== 1'b0 || f1 !== 4'd0) begin errors++; $display("FAIL mid_stale2 got f=%0d v=%0b exp 0", f1, fv1); end
        half();
        checks++; if (tv1 !== 1'b0) begin errors++; $display("FAIL mid_stale_t got %0b exp 0", tv1); end
        checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", cnt1); end
    endtask

    task automatic test_sweep();
        do_reset();
        in_valid = 1'b1; a8 = 8'd255; d8 = 8'd255; op = 1'b0;
        step();
        checks++; if (f2 !== 9'd510 || fv2 !== 1'b1) begin errors++; $display("FAIL sweep_add got f=%0d v=%0b exp f=510 v=1", f2, fv2); end
        a8 = 8'd0; d8 = 8'd1; op = 1'b1;
        step();
        in_valid = 1'b0; op = 1'b0;
        checks++; if (f2 !== 9'd511) begin errors++; $display("FAIL sweep_sub got %0d exp 511", f2); end
        half();
        checks++; if (t2 !== 9'd511 || tv2 !== 1'b1) begin errors++; $display("FAIL sweep_t got t=%0d v=%0b exp t=511 v=1", t2, tv2); end
        checks++; if (cnt2 !== 4'd2) begin errors++; $display("FAIL sweep_cnt got %0d exp 2", cnt2); end
        step();
        checks++; if (fv2 !== 1'b0 || f2 !== 9'd511) begin errors++; $display("FAIL sweep_bubble got f=%0d v=%0b exp f=511 v=0", f2, fv2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bubble();
        test_counter_wrap();
        test_depth3();
        test_reset_midflight();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
